draw_box: RTL and testbench
===========================

Name: draw_box

Overview:
- Downstream consumer of the star-mapping stages.
- After the mapping stages report a star's extent (xLeft, xRight, yTop, yBottom), the top-level FSM pulses goDraw. This block then rasterises a one-pixel-wide rectangle outline into the VGA adapter, one pixel per clock.
- It pulses doneDraw when the outline is complete, so the top FSM can continue scanning.

Parameters:
- X_W, 8, width of x coordinate (160-column screen)
- Y_W, 7, width of y coordinate (120-row screen)
- X_MAX, 159, largest legal x; larger inputs are clamped to it
- Y_MAX, 119, largest legal y; larger inputs are clamped to it
- COLOUR_W, 3, colour width (1 bit per channel, RGB)
- BOX_COLOUR, 3'b100, colour driven on every plotted pixel (red)

Ports:
- clk  input  1  system clock (CLOCK_50 at top level)
- resetn  input  1  asynchronous active-low reset
- goDraw  input  1  start pulse from top-level FSM; sampled only in IDLE
- xLeft  input  X_W  leftmost star column
- xRight  input  X_W  rightmost star column
- yTop  input  Y_W  topmost star row
- yBottom  input  Y_W  bottommost star row
- x  output  X_W  pixel x to VGA adapter
- y  output  Y_W  pixel y to VGA adapter
- colour  output  COLOUR_W  pixel colour to VGA adapter
- plot  output  1  write-enable to VGA adapter; x/y/colour valid when high
- busy  output  1  high from goDraw acceptance until doneDraw cycle inclusive
- doneDraw  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, doneDraw=0. All latched coordinates are cleared.
- Reset mid-draw: aborts immediately. No further plot and no doneDraw are issued.
- States: IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE.
- IDLE, goDraw=1 at edge k:
  - Latch the inputs.
  - Clamp: L'=min(xLeft,X_MAX), R'=min(xRight,X_MAX), T'=min(yTop,Y_MAX), B'=min(yBottom,Y_MAX).
  - Order: if L'>R', swap them; if T'>B', swap them. Result is L<=R, T<=B.
  - Set busy=1, go to TOP. The first pixel appears registered at edge k+1.
- TOP: plot=1, y=T, x steps L..R (one per cycle). After x=R, go to BOTTOM.
- BOTTOM: plot=1, y=B, x steps L..R. After x=R, go to LEFT.
- LEFT: plot=1, x=L, y steps T..B. After y=B, go to RIGHT.
- RIGHT: plot=1, x=R, y steps T..B. After y=B, go to DONE.
- Pixel count: W=R-L+1, H=B-T+1, total plot cycles N=2W+2H.
  - Corners and degenerate boxes are plotted more than once; this is intentional, no de-duplication.
- colour=BOX_COLOUR whenever plot=1, else 0.
- DONE (one cycle): plot=0, doneDraw=1, busy=1. Next cycle: IDLE, busy=0.
- Latency: goDraw edge to doneDraw = N+1 cycles.
- goDraw while busy: ignored, no queueing. Inputs changing while busy: ignored (latched copy is used).
- goDraw held high in IDLE after DONE: re-triggers a new draw; the top FSM must deassert it.
- Arithmetic: all unsigned. The step counters never exceed X_MAX/Y_MAX, so there is no wrap-around.

Decomposition:
- Shared package (star_pkg):
  - X_W, Y_W, X_MAX, Y_MAX, COLOUR_W
  - draw-state enum (IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE)
  - colour constants (BLACK, RED, WHITE)
  - all also reused by clean_star and the mapping stages
- One natural sub-module: edge_stepper.
  - Parameterised-width loadable up-counter with start/end values and a `last` flag (count==end).
  - draw_box instantiates one for x (X_W) and one for y (Y_W); the FSM selects which one steps.

Test Plan:
- L=10,R=12,T=5,B=6, goDraw pulse -> 10 plot cycles in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6),(10,5),(10,6),(12,5),(12,6); colour=3'b100; doneDraw 11 cycles after goDraw; busy low next cycle.
- L=R=20,T=B=30 -> 4 plot cycles all at (20,30); doneDraw at cycle 5.
- L=50,R=40,T=9,B=3 (reversed) -> drawn as L=40,R=50,T=3,B=9; N=2*11+2*7=36; first pixel (40,3), last (50,9).
- L=155,R=200,T=118,B=127 -> clamped to R=159,B=119; no x>159 or y>119 ever plotted; N=2*5+2*2=14.
- Second goDraw pulsed 3 cycles into a draw with different coordinates -> ignored; original outline completes unchanged; exactly one doneDraw.
- resetn low during LEFT state -> plot=0, busy=0, x=y=0 asynchronously; no doneDraw. A fresh goDraw after release draws the full box from the first pixel.

Source files
------------

// File: rtl/star_pkg.sv
// Shared constants and types for the star-mapping and drawing stages.
package star_pkg;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   localparam logic [X_W-1:0] X_MAX = 8'd159;
   localparam logic [Y_W-1:0] Y_MAX = 7'd119;

   localparam logic [COLOUR_W-1:0] BLACK      = 3'b000;
   localparam logic [COLOUR_W-1:0] RED        = 3'b100;
   localparam logic [COLOUR_W-1:0] WHITE      = 3'b111;
   localparam logic [COLOUR_W-1:0] BOX_COLOUR = RED;

   typedef enum logic [2:0] {
      IDLE,
      TOP,
      BOTTOM,
      LEFT,
      RIGHT,
      DONE
   } draw_state_t;

endpackage

// File: rtl/edge_stepper.sv
// Loadable up-counter walking one edge of the outline.
module edge_stepper #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_load,
   input  logic         i_step,
   input  logic [W-1:0] i_start,
   input  logic [W-1:0] i_end,
   output logic [W-1:0] o_count,
   output logic         o_last
);

   logic [W-1:0] r_count;

   // Stepping stops at the end value, so the count never wraps.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_start;
      end else if (i_step && !o_last) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == i_end);

endmodule

// File: rtl/draw_box.sv
// Rasterises a one-pixel rectangle outline into the VGA adapter.
import star_pkg::*;

module draw_box (
   input  logic                clk,
   input  logic                resetn,
   input  logic                goDraw,
   input  logic [X_W-1:0]      xLeft,
   input  logic [X_W-1:0]      xRight,
   input  logic [Y_W-1:0]      yTop,
   input  logic [Y_W-1:0]      yBottom,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                doneDraw
);

   draw_state_t r_state, w_next;

   logic [X_W-1:0] r_l, r_r;
   logic [Y_W-1:0] r_t, r_b;
   logic [X_W-1:0] w_lc, w_rc, w_l, w_r;
   logic [Y_W-1:0] w_tc, w_bc, w_t, w_b;

   logic           w_xload, w_xstep, w_xlast;
   logic           w_yload, w_ystep, w_ylast;
   logic [X_W-1:0] w_xstart, w_xcnt;
   logic [Y_W-1:0] w_ystart, w_ycnt;

   logic           w_plot, w_busy, w_done;
   logic [X_W-1:0] w_px;
   logic [Y_W-1:0] w_py;

   // Clamp to the screen, then order so that l<=r and t<=b.
   always_comb begin
      w_lc = (xLeft   > X_MAX) ? X_MAX : xLeft;
      w_rc = (xRight  > X_MAX) ? X_MAX : xRight;
      w_tc = (yTop    > Y_MAX) ? Y_MAX : yTop;
      w_bc = (yBottom > Y_MAX) ? Y_MAX : yBottom;
      w_l  = (w_lc > w_rc) ? w_rc : w_lc;
      w_r  = (w_lc > w_rc) ? w_lc : w_rc;
      w_t  = (w_tc > w_bc) ? w_bc : w_tc;
      w_b  = (w_tc > w_bc) ? w_tc : w_bc;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_l <= '0;
         r_r <= '0;
         r_t <= '0;
         r_b <= '0;
      end else if (r_state == IDLE && goDraw) begin
         r_l <= w_l;
         r_r <= w_r;
         r_t <= w_t;
         r_b <= w_b;
      end
   end

   edge_stepper #(.W(X_W)) u_xstep (
      .clk     (clk),
      .resetn  (resetn),
      .i_load  (w_xload),
      .i_step  (w_xstep),
      .i_start (w_xstart),
      .i_end   (r_r),
      .o_count (w_xcnt),
      .o_last  (w_xlast)
   );

   edge_stepper #(.W(Y_W)) u_ystep (
      .clk     (clk),
      .resetn  (resetn),
      .i_load  (w_yload),
      .i_step  (w_ystep),
      .i_start (w_ystart),
      .i_end   (r_b),
      .o_count (w_ycnt),
      .o_last  (w_ylast)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_xload  = 1'b0;
      w_xstep  = 1'b0;
      w_yload  = 1'b0;
      w_ystep  = 1'b0;
      w_xstart = r_l;
      w_ystart = r_t;
      w_plot   = 1'b0;
      w_busy   = 1'b1;
      w_done   = 1'b0;
      w_px     = x;
      w_py     = y;
      unique case (r_state)
         IDLE: begin
            // Latches are not yet loaded, so seed counters from inputs.
            w_xstart = w_l;
            w_ystart = w_t;
            w_busy   = goDraw;
            if (goDraw) begin
               w_next  = TOP;
               w_xload = 1'b1;
               w_yload = 1'b1;
            end
         end
         TOP: begin
            w_plot = 1'b1;
            w_px   = w_xcnt;
            w_py   = r_t;
            if (w_xlast) begin
               w_next  = BOTTOM;
               w_xload = 1'b1;
            end else begin
               w_xstep = 1'b1;
            end
         end
         BOTTOM: begin
            w_plot = 1'b1;
            w_px   = w_xcnt;
            w_py   = r_b;
            if (w_xlast) begin
               w_next  = LEFT;
               w_yload = 1'b1;
            end else begin
               w_xstep = 1'b1;
            end
         end
         LEFT: begin
            w_plot = 1'b1;
            w_px   = r_l;
            w_py   = w_ycnt;
            if (w_ylast) begin
               w_next  = RIGHT;
               w_yload = 1'b1;
            end else begin
               w_ystep = 1'b1;
            end
         end
         RIGHT: begin
            w_plot = 1'b1;
            w_px   = r_r;
            w_py   = w_ycnt;
            if (w_ylast) begin
               w_next = DONE;
            end else begin
               w_ystep = 1'b1;
            end
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_busy = 1'b0;
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x        <= '0;
         y        <= '0;
         colour   <= BLACK;
         plot     <= 1'b0;
         busy     <= 1'b0;
         doneDraw <= 1'b0;
      end else begin
         x        <= w_px;
         y        <= w_py;
         colour   <= w_plot ? BOX_COLOUR : BLACK;
         plot     <= w_plot;
         busy     <= w_busy;
         doneDraw <= w_done;
      end
   end

endmodule

// File: tb/tb_draw_box.sv
// Directed bench for draw_box with a pixel-list reference model.
module tb_draw_box;
   import star_pkg::*;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                goDraw = 1'b0;
   logic [X_W-1:0]      xLeft = '0;
   logic [X_W-1:0]      xRight = '0;
   logic [Y_W-1:0]      yTop = '0;
   logic [Y_W-1:0]      yBottom = '0;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                doneDraw;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cap_x[$];
   int cap_y[$];

   draw_box dut (
      .clk      (clk),
      .resetn   (resetn),
      .goDraw   (goDraw),
      .xLeft    (xLeft),
      .xRight   (xRight),
      .yTop     (yTop),
      .yBottom  (yBottom),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy),
      .doneDraw (doneDraw)
   );

   always #5 clk = ~clk;

   // Reference: on acceptance, list every outline pixel, then
   // replay one per cycle followed by a single done cycle.
   int mq_x[$];
   int mq_y[$];
   int m_st;
   int ml, mr, mt, mb, mtmp;
   logic e_plot, e_busy, e_done;
   int e_x, e_y;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_st = 0;
         mq_x.delete();
         mq_y.delete();
         e_plot = 0;
         e_busy = 0;
         e_done = 0;
         e_x = 0;
         e_y = 0;
      end else begin
         e_plot = 0;
         e_done = 0;
         if (m_st == 0) begin
            e_busy = 0;
            if (goDraw) begin
               ml = (int'(xLeft) > 159) ? 159 : int'(xLeft);
               mr = (int'(xRight) > 159) ? 159 : int'(xRight);
               mt = (int'(yTop) > 119) ? 119 : int'(yTop);
               mb = (int'(yBottom) > 119) ? 119 : int'(yBottom);
               if (ml > mr) begin mtmp = ml; ml = mr; mr = mtmp; end
               if (mt > mb) begin mtmp = mt; mt = mb; mb = mtmp; end
               for (int i = ml; i <= mr; i++) begin
                  mq_x.push_back(i); mq_y.push_back(mt);
               end
               for (int i = ml; i <= mr; i++) begin
                  mq_x.push_back(i); mq_y.push_back(mb);
               end
               for (int i = mt; i <= mb; i++) begin
                  mq_x.push_back(ml); mq_y.push_back(i);
               end
               for (int i = mt; i <= mb; i++) begin
                  mq_x.push_back(mr); mq_y.push_back(i);
               end
               m_st = 1;
               e_busy = 1;
            end
         end else if (mq_x.size() > 0) begin
            e_plot = 1;
            e_x = mq_x.pop_front();
            e_y = mq_y.pop_front();
         end else begin
            e_done = 1;
            m_st = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic cmp();
      logic [COLOUR_W-1:0] ec;
      ec = e_plot ? 3'b100 : 3'b000;
      checks++;
      if (plot !== e_plot || busy !== e_busy ||
          doneDraw !== e_done || colour !== ec) begin
         errors++;
         $display("FAIL ctrl t=%0t plot/busy/done/col got %b%b%b/%b want %b%b%b/%b",
                  $time, plot, busy, doneDraw, colour,
                  e_plot, e_busy, e_done, ec);
      end
      if (e_plot || !resetn) begin
         checks++;
         if (x !== e_x[X_W-1:0] || y !== e_y[Y_W-1:0]) begin
            errors++;
            $display("FAIL pixel t=%0t got (%0d,%0d) want (%0d,%0d)",
                     $time, x, y, e_x, e_y);
         end
      end
      if (plot === 1'b1) begin
         checks++;
         if (int'(x) > 159 || int'(y) > 119) begin
            errors++;
            $display("FAIL bounds got (%0d,%0d) want x<=159 y<=119", x, y);
         end
         cap_x.push_back(int'(x));
         cap_y.push_back(int'(y));
      end
      if (doneDraw === 1'b1) done_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      cmp();
   endtask

   task automatic start(input int l, input int r, input int t, input int b);
      tick();
      xLeft = l[X_W-1:0];
      xRight = r[X_W-1:0];
      yTop = t[Y_W-1:0];
      yBottom = b[Y_W-1:0];
      goDraw = 1'b1;
      cap_x.delete();
      cap_y.delete();
      tick();
      goDraw = 1'b0;
   endtask

   task automatic run_box(input int l, input int r, input int t,
                          input int b, input bit intf, output int lat);
      start(l, r, t, b);
      lat = 400;
      for (int c = 1; c <= 400; c++) begin
         tick();
         if (intf && c == 3) begin
            goDraw = 1'b1;
            xLeft = 8'd0; xRight = 8'd100;
            yTop = 7'd0; yBottom = 7'd100;
         end
         if (intf && c == 4) goDraw = 1'b0;
         if (doneDraw === 1'b1) begin
            lat = c;
            break;
         end
      end
      tick();
      chk("busy_after_done", int'(busy), 0);
   endtask

   int ex1[10] = '{10, 11, 12, 10, 11, 12, 10, 10, 12, 12};
   int ey1[10] = '{5, 5, 5, 6, 6, 6, 5, 6, 5, 6};
   int lat, d0, mx, my;

   initial begin
      #1;
      chk("reset_plot", int'(plot), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_xy", int'(x) + int'(y), 0);
      chk("reset_colour", int'(colour), 0);
      repeat (2) tick();
      resetn = 1'b1;

      run_box(10, 12, 5, 6, 1'b0, lat);
      chk("t1_latency", lat, 11);
      chk("t1_count", cap_x.size(), 10);
      for (int i = 0; i < 10 && i < cap_x.size(); i++) begin
         chk("t1_px", cap_x[i], ex1[i]);
         chk("t1_py", cap_y[i], ey1[i]);
      end

      run_box(20, 20, 30, 30, 1'b0, lat);
      chk("t2_latency", lat, 5);
      chk("t2_count", cap_x.size(), 4);
      for (int i = 0; i < cap_x.size(); i++) begin
         chk("t2_px", cap_x[i], 20);
         chk("t2_py", cap_y[i], 30);
      end

      run_box(50, 40, 9, 3, 1'b0, lat);
      chk("t3_latency", lat, 37);
      chk("t3_count", cap_x.size(), 36);
      if (cap_x.size() > 0) begin
         chk("t3_first_x", cap_x[0], 40);
         chk("t3_first_y", cap_y[0], 3);
         chk("t3_last_x", cap_x[cap_x.size()-1], 50);
         chk("t3_last_y", cap_y[cap_y.size()-1], 9);
      end

      run_box(155, 200, 118, 127, 1'b0, lat);
      chk("t4_latency", lat, 15);
      chk("t4_count", cap_x.size(), 14);
      mx = 0;
      my = 0;
      foreach (cap_x[i]) begin
         if (cap_x[i] > mx) mx = cap_x[i];
         if (cap_y[i] > my) my = cap_y[i];
      end
      chk("t4_max_x", mx, 159);
      chk("t4_max_y", my, 119);

      d0 = done_cnt;
      run_box(10, 12, 5, 6, 1'b1, lat);
      chk("t5_latency", lat, 11);
      chk("t5_count", cap_x.size(), 10);
      chk("t5_dones", done_cnt - d0, 1);
      for (int i = 0; i < 10 && i < cap_x.size(); i++) begin
         chk("t5_px", cap_x[i], ex1[i]);
         chk("t5_py", cap_y[i], ey1[i]);
      end

      start(10, 12, 5, 6);
      repeat (7) tick();
      chk("t6_in_left_x", int'(x), 10);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_plot", int'(plot), 0);
      chk("t6_async_busy", int'(busy), 0);
      chk("t6_async_x", int'(x), 0);
      chk("t6_async_y", int'(y), 0);
      d0 = done_cnt;
      repeat (3) tick();
      resetn = 1'b1;
      repeat (20) tick();
      chk("t6_no_done", done_cnt - d0, 0);
      run_box(10, 12, 5, 6, 1'b0, lat);
      chk("t6_latency", lat, 11);
      chk("t6_count", cap_x.size(), 10);
      if (cap_x.size() > 0) begin
         chk("t6_first_x", cap_x[0], 10);
         chk("t6_first_y", cap_y[0], 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
